kcpsm_port_hub: RTL
===================

// Module: kcpsm_port_hub
// PURPOSE
//  Parametrised PicoBlaze (KCPSM6) I/O hub that replaces the hand-written port decode in the top level.
//  Provides N_OUT write registers with one-cycle write pulses and N_IN read channels with a registered input mux.
//  Adds a maskable, edge-triggered interrupt controller for N_IRQ external sources, such as the RTC IRQ and the
//  keyboard, which drives the KCPSM6 interrupt/interrupt_ack handshake. Sits between the processor and the RTC/VGA/PS2 blocks.
// PARAMETERS
//  N_OUT     8      number of write registers, port_id OUT_BASE..OUT_BASE+N_OUT-1
//  OUT_BASE  8'h02  first write port id
//  OUT_RST   8'h00  reset value of every write register
//  N_IN      4      number of read channels, port_id IN_BASE..IN_BASE+N_IN-1
//  IN_BASE   8'h0C  first read port id
//  N_IRQ     2      interrupt sources (1..8)
//  IRQ_POL   2'b01  per-source polarity; 1 = active-low input (inverted before edge detect)
//  MASK_PORT 8'h20  port id of the IRQ mask register (R/W)
//  STAT_PORT 8'h21  port id of the IRQ pending register (read; write-1-to-clear)
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  port_id        in   8          from KCPSM6
//  out_port       in   8          from KCPSM6
//  write_strobe   in   1          from KCPSM6
//  read_strobe    in   1          from KCPSM6
//  in_port        out  8          to KCPSM6, registered
//  interrupt      out  1          to KCPSM6
//  interrupt_ack  in   1          from KCPSM6
//  out_regs       out  N_OUT*8    write registers; register k is at [8k+7:8k]
//  out_wr         out  N_OUT      one-cycle pulse for register k, aligned with its update
//  in_data        in   N_IN*8     read channel data; channel k is at [8k+7:8k]
//  in_rd          out  N_IN       one-cycle pulse when channel k is read (FIFO pop / flag clear)
//  irq_in         in   N_IRQ      asynchronous interrupt sources
// BEHAVIOUR
//  Reset
//   - out_regs = OUT_RST; out_wr = 0; in_rd = 0; in_port = 0; interrupt = 0.
//   - mask = 0; pending = 0; served = 0; synchronisers are loaded with the inactive level.
//  Write path
//   - write_strobe && port_id == OUT_BASE+k: out_regs[k] <= out_port at the next edge; out_wr[k] = 1 for exactly that cycle.
//   - Port ids outside all mapped ranges are ignored. MASK_PORT and STAT_PORT take priority over any range overlap.
//  Read path
//   - Every cycle, in_port <= the selected source: in_data[k] for IN_BASE+k, {0,mask} for MASK_PORT,
//     {0,pending} for STAT_PORT, otherwise 0. Latency is 1 cycle, which meets the KCPSM6 2-cycle INPUT window.
//   - read_strobe && port_id == IN_BASE+k: in_rd[k] = 1 for one cycle, registered.
//  IRQ path
//   - Each irq_in bit is XORed with IRQ_POL, then passed through a 2-FF synchroniser and a rising-edge detector.
//   - A detected edge sets pending[i]. A W1C write to STAT_PORT clears the bits written as 1.
//   - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
//   - A write to MASK_PORT loads mask <= out_port[N_IRQ-1:0].
//  Interrupt FSM (states IDLE, REQ, SERVED)
//   - IDLE -> REQ when |(pending & mask); interrupt = 1 while in REQ.
//   - REQ -> SERVED on interrupt_ack; interrupt = 0 in the cycle after the ack.
//   - REQ -> IDLE when (pending & mask) == 0 before any ack (withdrawn request).
//   - SERVED -> IDLE on any write to STAT_PORT. A new request can then be raised on the next cycle.
//   - Edges that arrive while in SERVED are latched in pending and do not re-assert interrupt until the FSM is back in IDLE.
//  Reset asserted mid-operation aborts the FSM to IDLE and clears pending in the same edge.
// STRUCTURE
//  - Shared package: the state encoding localparams (ST_IDLE, ST_REQ, ST_SERVED) and the default port-id
//    constants, kept consistent with the assembler include file.
//  - One sub-module, kcpsm_irq_ctrl: synchronisers, edge detection, pending/mask registers and the FSM.
//  - The hub keeps the decode, the write registers and the input mux.
// TESTING
//  1. Write 8'hA5 to port 8'h03 -> out_regs[1] = 8'hA5 next cycle, out_wr = 8'b0000_0010 for 1 cycle, other registers unchanged.
//  2. in_data[2] = 8'h3C, port_id = 8'h0E, read_strobe pulse -> in_port = 8'h3C one cycle later, in_rd[2] pulses once.
//  3. Set mask = 2'b01, drive irq_in[0] low (active-low) -> interrupt = 1 within 4 cycles;
//     interrupt_ack -> interrupt = 0; reading STAT_PORT returns 8'h01.
//  4. Pulse irq_in[1] with mask = 2'b01 -> pending = 2'b10, interrupt stays 0; write mask = 2'b11 -> interrupt = 1.
//  5. In SERVED, fire a second edge on source 0, then write 8'h01 to STAT_PORT in the same cycle ->
//     pending[0] stays 1, FSM returns to IDLE and interrupt re-asserts.
//  6. Assert reset while in REQ with out_regs loaded -> all outputs return to reset values;
//     no spurious out_wr or in_rd pulse.

Source files
------------

// File: rtl/kcpsm_port_hub_pkg.sv
// Shared constants for the KCPSM6 port hub.
// Holds the interrupt FSM state encoding and the default port-id map.
// The port ids here must match the assembler include file used by the firmware.
package kcpsm_port_hub_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_SERVED = 2'd2;

    localparam logic [7:0] DEF_OUT_BASE  = 8'h02;
    localparam logic [7:0] DEF_IN_BASE   = 8'h0C;
    localparam logic [7:0] DEF_MASK_PORT = 8'h20;
    localparam logic [7:0] DEF_STAT_PORT = 8'h21;

    // True when id addresses entry k of a block that starts at base.
    function automatic logic port_hit(input logic [7:0] id, input logic [7:0] base, input int k);
        return id == (base + 8'(k));
    endfunction

endpackage

// File: rtl/kcpsm_irq_ctrl.sv
// Edge-triggered, maskable interrupt controller for the KCPSM6 handshake.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   irq_in          raw asynchronous sources (polarity set by IRQ_POL, 1 = active-low)
//   mask_wr         load mask from wr_data this cycle
//   stat_wr         write-1-to-clear pending with wr_data this cycle
//   wr_data         low N_IRQ bits of the processor out_port
//   interrupt_ack   from KCPSM6
//   mask, pending   register contents, for read-back through the hub
//   interrupt       to KCPSM6
//
// state     | meaning
// ST_IDLE   | no request outstanding, waiting for an unmasked pending bit
// ST_REQ    | interrupt asserted, waiting for interrupt_ack
// ST_SERVED | acknowledged, handler running until it writes the status port
module kcpsm_irq_ctrl
    import kcpsm_port_hub_pkg::*;
#(
    parameter int               N_IRQ   = 2,
    parameter logic [N_IRQ-1:0] IRQ_POL = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_wr,
    input  logic             stat_wr,
    input  logic [N_IRQ-1:0] wr_data,
    input  logic             interrupt_ack,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending,
    output logic             interrupt
);

    logic [N_IRQ-1:0] sync_a;
    logic [N_IRQ-1:0] sync_b;
    logic [N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [1:0]       state;

    // Sources are normalised to active-high before the synchroniser, so the
    // reset value 0 is the inactive level for every source.
    assign rise = sync_b & ~sync_q;
    assign clr  = stat_wr ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            sync_q  <= '0;
            mask    <= '0;
            pending <= '0;
            state   <= ST_IDLE;
        end else begin
            sync_a <= irq_in ^ IRQ_POL;
            sync_b <= sync_a;
            sync_q <= sync_b;
            if (mask_wr) begin
                mask <= wr_data;
            end
            // A new edge beats a simultaneous clear so no event is lost.
            pending <= (pending & ~clr) | rise;
            case (state)
                ST_IDLE: begin
                    if (|(pending & mask)) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (interrupt_ack)              state <= ST_SERVED;
                    else if ((pending & mask) == '0) state <= ST_IDLE;
                end
                ST_SERVED: begin
                    if (stat_wr) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign interrupt = (state == ST_REQ);

endmodule

// File: rtl/kcpsm_port_hub.sv
// KCPSM6 I/O hub: write registers with update pulses, registered input mux
// with read pulses, and the IRQ mask/status ports backed by kcpsm_irq_ctrl.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   port_id, out_port          KCPSM6 address and write data
//   write_strobe, read_strobe  KCPSM6 strobes
//   in_port                    registered read data to KCPSM6
//   interrupt, interrupt_ack   KCPSM6 interrupt handshake
//   out_regs, out_wr           write registers (byte k at [8k+7:8k]) and update pulses
//   in_data, in_rd             read channels (byte k at [8k+7:8k]) and read pulses
//   irq_in                     asynchronous interrupt sources
module kcpsm_port_hub
    import kcpsm_port_hub_pkg::*;
#(
    parameter int               N_OUT     = 8,
    parameter logic [7:0]       OUT_BASE  = DEF_OUT_BASE,
    parameter logic [7:0]       OUT_RST   = 8'h00,
    parameter int               N_IN      = 4,
    parameter logic [7:0]       IN_BASE   = DEF_IN_BASE,
    parameter int               N_IRQ     = 2,
    parameter logic [N_IRQ-1:0] IRQ_POL   = 2'b01,
    parameter logic [7:0]       MASK_PORT = DEF_MASK_PORT,
    parameter logic [7:0]       STAT_PORT = DEF_STAT_PORT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         in_port,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [N_OUT*8-1:0] out_regs,
    output logic [N_OUT-1:0]   out_wr,
    input  logic [N_IN*8-1:0]  in_data,
    output logic [N_IN-1:0]    in_rd,
    input  logic [N_IRQ-1:0]   irq_in
);

    logic             is_mask;
    logic             is_stat;
    logic [N_OUT-1:0] wr_hit;
    logic [N_IN-1:0]  rd_hit;
    logic [7:0]       rd_sel;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pending;

    // The IRQ ports override any overlap with the register/channel ranges.
    always_comb begin
        is_mask = (port_id == MASK_PORT);
        is_stat = (port_id == STAT_PORT);
        wr_hit  = '0;
        rd_hit  = '0;
        rd_sel  = 8'h00;
        for (int k = 0; k < N_OUT; k++) begin
            wr_hit[k] = write_strobe && !is_mask && !is_stat && port_hit(port_id, OUT_BASE, k);
        end
        for (int k = 0; k < N_IN; k++) begin
            if (port_hit(port_id, IN_BASE, k)) begin
                rd_sel    = in_data[8*k +: 8];
                rd_hit[k] = read_strobe && !is_mask && !is_stat;
            end
        end
        if (is_mask) begin
            rd_sel = 8'(mask);
        end else if (is_stat) begin
            rd_sel = 8'(pending);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_regs <= {N_OUT{OUT_RST}};
            out_wr   <= '0;
            in_rd    <= '0;
            in_port  <= 8'h00;
        end else begin
            out_wr  <= wr_hit;
            in_rd   <= rd_hit;
            in_port <= rd_sel;
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_hit[k]) out_regs[8*k +: 8] <= out_port;
            end
        end
    end

    kcpsm_irq_ctrl #(
        .N_IRQ   (N_IRQ),
        .IRQ_POL (IRQ_POL)
    ) u_irq (
        .clk           (clk),
        .reset         (reset),
        .irq_in        (irq_in),
        .mask_wr       (write_strobe && is_mask),
        .stat_wr       (write_strobe && is_stat),
        .wr_data       (out_port[N_IRQ-1:0]),
        .interrupt_ack (interrupt_ack),
        .mask          (mask),
        .pending       (pending),
        .interrupt     (interrupt)
    );

endmodule
